y86_pipe_ctrl: RTL and testbench

//  Pipeline control and status unit for the 5-stage Y86-64 core (F/D/E/M/W).
//  It is the successor to the single-cycle SEQ status logic, generalised to a pipeline.
//  - Generates stall and bubble controls for load-use, ret and mispredicted-jump hazards.
//  - Tracks the architectural status code (AOK/HLT/ADR/INS) through a halt FSM.
//  - Counts cycles and retired instructions, and trips a watchdog on runaway programs.

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/y86_hazard_detect.sv | 48 ++++
 rtl/y86_pipe_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_y86_pipe_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
//   Shared definitions for the Y86-64 pipeline control slice: instruction
//   codes, the register-id "no register" value, architectural status codes,
//   the halt-FSM state type and the bundle of pipeline control signals.
//   No ports (package).
// -----------------------------------------------------------------------------
package y86_pkg;

   // Instruction codes (icode field)
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // "No register" id for the default 4-bit register file
   localparam logic [3:0] RNONE = 4'hF;

   // Architectural status codes
   localparam logic [2:0] S_BUB = 3'd0;
   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   // Halt FSM
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Pipeline register controls, grouped so they can be defaulted in one go
   typedef struct packed {
      logic f_stall;
      logic d_stall;
      logic d_bubble;
      logic e_bubble;
      logic m_bubble;
      logic w_stall;
      logic set_cc;
   } ctrl_t;

   // A status is exceptional unless it is a bubble or a normal instruction
   function automatic logic is_exc(input logic [2:0] s);
      return (s != S_BUB) && (s != S_AOK);
   endfunction

endpackage

// File: rtl/y86_hazard_detect.sv
// -----------------------------------------------------------------------------
// y86_hazard_detect
//   Purely combinational detection of the three pipeline hazard conditions.
//   Ports:
//     D_icode, E_icode, M_icode  in  icodes in Decode / Execute / Memory
//     d_srcA, d_srcB             in  decode source register ids
//     E_dstM                     in  load destination register in Execute
//     e_Cnd                      in  jump condition outcome in Execute
//     lu                         out load-use: Decode needs a value still being loaded
//     ret                        out a ret is somewhere in Decode..Memory
//     mp                         out the jump in Execute was mispredicted (not taken)
// -----------------------------------------------------------------------------
module y86_hazard_detect
   import y86_pkg::*;
#(
   parameter int REG_W = 4
) (
   input  logic [3:0]       D_icode,
   input  logic [REG_W-1:0] d_srcA,
   input  logic [REG_W-1:0] d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [REG_W-1:0] E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   output logic             lu,
   output logic             ret,
   output logic             mp
);

   // All-ones register id means "no register" at any REG_W
   localparam logic [REG_W-1:0] REG_NONE = '1;

   logic e_is_load;
   logic src_match;

   assign e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
   assign src_match = (E_dstM == d_srcA) || (E_dstM == d_srcB);

   // RNONE must be excluded: an unused decode source is also RNONE and
   // would otherwise match a load that writes no register.
   assign lu  = e_is_load && (E_dstM != REG_NONE) && src_match;

   assign ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

   // Branches are predicted taken, so a not-taken jump is the misprediction
   assign mp  = (E_icode == I_JXX) && !e_Cnd;

endmodule

// File: rtl/y86_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// y86_pipe_ctrl
//   Pipeline control and status unit for the 5-stage Y86-64 core.
//   Generates stall/bubble controls for load-use, ret and mispredict hazards,
//   tracks the architectural status through a RUN/DRAIN/HALTED FSM, counts
//   RUN cycles and retired instructions, and halts runaway programs with a
//   watchdog.
//   Ports:
//     clk, rst                 in  clock (rising edge), synchronous active-high reset
//     D_icode,d_srcA,d_srcB    in  Decode-stage icode and source registers
//     E_icode,E_dstM,e_Cnd     in  Execute-stage icode, load destination, jump outcome
//     M_icode,m_stat           in  Memory-stage icode and status
//     W_stat                   in  Writeback-stage status
//     F_stall,D_stall,W_stall  out hold PC / D / W registers
//     D_bubble,E_bubble,M_bubble out insert NOP into D / E / M
//     set_cc                   out condition-code write enable
//     stat_out                 out registered processor status
//     halted, wdog_trip        out sticky stop flag / stop caused by watchdog
//     cycle_cnt, retired_cnt   out saturating RUN-cycle / retired-instruction counts
// -----------------------------------------------------------------------------
module y86_pipe_ctrl
   import y86_pkg::*;
#(
   parameter int CNT_W      = 64,
   parameter int MAX_CYCLES = 1024,
   parameter int REG_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       D_icode,
   input  logic [REG_W-1:0] d_srcA,
   input  logic [REG_W-1:0] d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [REG_W-1:0] E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic             M_bubble,
   output logic             W_stall,
   output logic             set_cc,
   output logic [2:0]       stat_out,
   output logic             halted,
   output logic             wdog_trip,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Compare in a width wider than any counter so a limit beyond the
   // counter range simply never fires instead of aliasing after truncation.
   localparam logic [64:0] WDOG_LAST = 65'(MAX_CYCLES) - 65'd1;

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl;

   logic lu;
   logic ret;
   logic mp;
   logic m_exc;
   logic w_exc;
   logic wdog_fire;

   // ---------------------------------------------------------------------
   // Hazard terms
   // ---------------------------------------------------------------------
   y86_hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard (
      .D_icode (D_icode),
      .d_srcA  (d_srcA),
      .d_srcB  (d_srcB),
      .E_icode (E_icode),
      .E_dstM  (E_dstM),
      .e_Cnd   (e_Cnd),
      .M_icode (M_icode),
      .lu      (lu),
      .ret     (ret),
      .mp      (mp)
   );

   assign m_exc     = is_exc(m_stat);
   assign w_exc     = is_exc(W_stat);
   assign wdog_fire = (MAX_CYCLES != 0) && (65'(cycle_cnt) == WDOG_LAST);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every variable written in an always_comb gets a default on the
   // first line, so no path through the block can leave it unassigned and
   // infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_RUN: begin
            // The exception is checked first so it wins over the watchdog
            if (w_exc) begin
               state_nxt = ST_DRAIN;
            end else if (wdog_fire) begin
               state_nxt = ST_HALTED;
            end
         end
         ST_DRAIN:  state_nxt = ST_HALTED;
         ST_HALTED: state_nxt = ST_HALTED;
         default:   state_nxt = ST_RUN;
      endcase
   end

   // ---------------------------------------------------------------------
   // Pipeline controls (same-cycle, no register)
   // ---------------------------------------------------------------------
   always_comb begin
      ctrl = '0;
      if (rst) begin
         // Flush every stage while reset is held
         ctrl.d_bubble = 1'b1;
         ctrl.e_bubble = 1'b1;
         ctrl.m_bubble = 1'b1;
      end else if (state == ST_RUN) begin
         ctrl.f_stall  = lu | ret;
         // A mispredict squashes D, so stalling it at the same time is moot
         ctrl.d_stall  = lu & ~mp;
         // On load-use the ret stays in D (stalled), so no bubble there yet
         ctrl.d_bubble = mp | (ret & ~lu);
         ctrl.e_bubble = mp | lu;
         ctrl.m_bubble = m_exc | w_exc;
         ctrl.w_stall  = w_exc;
         // Instructions behind an exception must not change the flags
         ctrl.set_cc   = (E_icode == I_OPQ) & ~m_exc & ~w_exc;
      end else begin
         // DRAIN / HALTED: freeze fetch and writeback, flush the middle
         ctrl.f_stall  = 1'b1;
         ctrl.w_stall  = 1'b1;
         ctrl.d_bubble = 1'b1;
         ctrl.e_bubble = 1'b1;
         ctrl.m_bubble = 1'b1;
      end
   end

   assign F_stall  = ctrl.f_stall;
   assign D_stall  = ctrl.d_stall;
   assign D_bubble = ctrl.d_bubble;
   assign E_bubble = ctrl.e_bubble;
   assign M_bubble = ctrl.m_bubble;
   assign W_stall  = ctrl.w_stall;
   assign set_cc   = ctrl.set_cc;

   // ---------------------------------------------------------------------
   // State, status and counters
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this edge regardless of the
   // order of statements or of other always_ff blocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         stat_out    <= S_AOK;
         halted      <= 1'b0;
         wdog_trip   <= 1'b0;
         cycle_cnt   <= '0;
         retired_cnt <= '0;
      end else begin
         state <= state_nxt;

         if (state == ST_RUN) begin
            if (cycle_cnt != CNT_MAX) begin
               cycle_cnt <= cycle_cnt + 1'b1;
            end
            if ((W_stat == S_AOK) && (retired_cnt != CNT_MAX)) begin
               retired_cnt <= retired_cnt + 1'b1;
            end

            if (w_exc) begin
               stat_out <= W_stat;
            end else if (wdog_fire) begin
               stat_out  <= S_HLT;
               wdog_trip <= 1'b1;
            end
         end

         if (state_nxt == ST_HALTED) begin
            halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_y86_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_y86_pipe_ctrl
//   Self-checking bench for y86_pipe_ctrl. Three instances share one stimulus:
//     u_a  default parameters          (hazard table, ret, ADR drain, random)
//     u_w  MAX_CYCLES = 20             (watchdog and exception-vs-watchdog)
//     u_s  CNT_W = 4, watchdog off     (counter saturation and reset from HALTED)
//   Control outputs are packed as {F_stall,D_stall,D_bubble,E_bubble,
//   M_bubble,W_stall,set_cc}.
// -----------------------------------------------------------------------------
module tb_y86_pipe_ctrl;

   localparam int MAX_A = 1024;

   localparam logic [6:0] C_RST  = 7'b0011100;
   localparam logic [6:0] C_HOLD = 7'b1011110;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic       e_Cnd;
   logic [2:0] m_stat, W_stat;

   logic [6:0]  ctl_a, ctl_w, ctl_s;
   logic [2:0]  stat_a, stat_w, stat_s;
   logic        halted_a, halted_w, halted_s;
   logic        wd_a, wd_w, wd_s;
   logic [63:0] cyc_a, ret_a, cyc_w, ret_w;
   logic [3:0]  cyc_s, ret_s;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   y86_pipe_ctrl u_a (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(ctl_a[6]), .D_stall(ctl_a[5]), .D_bubble(ctl_a[4]), .E_bubble(ctl_a[3]),
      .M_bubble(ctl_a[2]), .W_stall(ctl_a[1]), .set_cc(ctl_a[0]),
      .stat_out(stat_a), .halted(halted_a), .wdog_trip(wd_a),
      .cycle_cnt(cyc_a), .retired_cnt(ret_a)
   );

   y86_pipe_ctrl #(.MAX_CYCLES(20)) u_w (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(ctl_w[6]), .D_stall(ctl_w[5]), .D_bubble(ctl_w[4]), .E_bubble(ctl_w[3]),
      .M_bubble(ctl_w[2]), .W_stall(ctl_w[1]), .set_cc(ctl_w[0]),
      .stat_out(stat_w), .halted(halted_w), .wdog_trip(wd_w),
      .cycle_cnt(cyc_w), .retired_cnt(ret_w)
   );

   y86_pipe_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) u_s (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
      .m_stat(m_stat), .W_stat(W_stat),
      .F_stall(ctl_s[6]), .D_stall(ctl_s[5]), .D_bubble(ctl_s[4]), .E_bubble(ctl_s[3]),
      .M_bubble(ctl_s[2]), .W_stall(ctl_s[1]), .set_cc(ctl_s[0]),
      .stat_out(stat_s), .halted(halted_s), .wdog_trip(wd_s),
      .cycle_cnt(cyc_s), .retired_cnt(ret_s)
   );

   // ---------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic set_idle();
      D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
      E_icode = 4'h1; E_dstM = 4'hF; e_Cnd  = 1'b0;
      M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1;
   endtask

   // Finish the current cycle: inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Reference model for the random phase (u_a)
   // ---------------------------------------------------------------------
   int              md_mode;     // 0 running, 1 draining, 2 stopped
   logic [2:0]      md_stat;
   logic            md_halted, md_wd;
   longint unsigned md_cyc, md_ret;

   function automatic logic exc(input logic [2:0] s);
      return !(s == 3'd0 || s == 3'd1);
   endfunction

   function automatic logic [6:0] model_ctrl();
      logic is_load, lu, rt, mp, me, we;
      if (rst) return C_RST;
      if (md_mode != 0) return C_HOLD;
      is_load = (E_icode == 4'h5) || (E_icode == 4'hB);
      lu = is_load && (E_dstM != 4'hF) && (E_dstM == d_srcA || E_dstM == d_srcB);
      rt = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
      mp = (E_icode == 4'h7) && !e_Cnd;
      me = exc(m_stat);
      we = exc(W_stat);
      return {lu || rt, lu && !mp, mp || (rt && !lu), mp || lu, me || we, we,
              (E_icode == 4'h6) && !me && !we};
   endfunction

   task automatic model_edge();
      longint unsigned cyc_before;
      if (rst) begin
         md_mode = 0; md_stat = 3'd1; md_halted = 0; md_wd = 0; md_cyc = 0; md_ret = 0;
      end else if (md_mode == 0) begin
         cyc_before = md_cyc;
         md_cyc++;
         if (W_stat == 3'd1) md_ret++;
         if (exc(W_stat)) begin
            md_mode = 1; md_stat = W_stat;
         end else if (cyc_before == longint'(MAX_A - 1)) begin
            md_mode = 2; md_stat = 3'd2; md_wd = 1; md_halted = 1;
         end
      end else begin
         md_mode = 2; md_halted = 1;
      end
   endtask

   // ---------------------------------------------------------------------
   // Combinational control vectors
   // ---------------------------------------------------------------------
   typedef struct {
      string      name;
      logic [3:0] d_ic, sa, sb, e_ic, dm;
      logic       cnd;
      logic [3:0] m_ic;
      logic [2:0] ms, ws;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[17];

   initial begin
      //            name              D     srcA  srcB  E     dstM  Cnd   M     m_st  W_st  expected
      vecs[0]  = '{"idle",           4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0000000};
      vecs[1]  = '{"lu_mrmov_srcA",  4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1101000};
      vecs[2]  = '{"lu_popq_srcB",   4'h1, 4'hF, 4'h4, 4'hB, 4'h4, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1101000};
      vecs[3]  = '{"load_rnone",     4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0000000};
      vecs[4]  = '{"load_nomatch",   4'h1, 4'h3, 4'h4, 4'h5, 4'h2, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0000000};
      vecs[5]  = '{"ret_in_D",       4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1010000};
      vecs[6]  = '{"ret_in_E",       4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1010000};
      vecs[7]  = '{"ret_in_M",       4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h9, 3'd1, 3'd1, 7'b1010000};
      vecs[8]  = '{"mispredict",     4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0011000};
      vecs[9]  = '{"jump_taken",     4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 7'b0000000};
      vecs[10] = '{"mp_lu_regs",     4'h1, 4'h3, 4'hF, 4'h7, 4'h3, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0011000};
      vecs[11] = '{"lu_and_ret",     4'h9, 4'h2, 4'hF, 4'h5, 4'h2, 1'b0, 4'h1, 3'd1, 3'd1, 7'b1101000};
      vecs[12] = '{"opq_set_cc",     4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 7'b0000001};
      vecs[13] = '{"opq_m_adr",      4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd3, 3'd1, 7'b0000100};
      vecs[14] = '{"opq_bubbles",    4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd0, 3'd0, 7'b0000001};
      vecs[15] = '{"m_ins",          4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd4, 3'd0, 7'b0000100};
      vecs[16] = '{"mp_ret_in_M",    4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h9, 3'd1, 3'd1, 7'b1011000};
   end

   // ---------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      set_idle();

      // Reset: forced controls while held, reset values after the edge
      @(negedge clk);
      check("rst_ctrl", 64'(ctl_a), 64'(C_RST));
      tick();
      check("rst_stat", 64'(stat_a), 64'd1);
      check("rst_halted", 64'(halted_a), 64'd0);
      check("rst_wdog", 64'(wd_a), 64'd0);
      check("rst_cycles", cyc_a, 64'd0);
      check("rst_retired", ret_a, 64'd0);
      rst = 1'b0;

      // Table of single-cycle hazard combinations (u_a stays in RUN)
      for (int i = 0; i < 17; i++) begin
         D_icode = vecs[i].d_ic; d_srcA = vecs[i].sa; d_srcB = vecs[i].sb;
         E_icode = vecs[i].e_ic; E_dstM = vecs[i].dm; e_Cnd  = vecs[i].cnd;
         M_icode = vecs[i].m_ic; m_stat = vecs[i].ms; W_stat = vecs[i].ws;
         @(negedge clk);
         check(vecs[i].name, 64'(ctl_a), 64'(vecs[i].exp));
         tick();
      end

      // ret walking through D, E, M, then gone
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_idle();
         if (c == 0) D_icode = 4'h9;
         if (c == 1) E_icode = 4'h9;
         if (c == 2) M_icode = 4'h9;
         @(negedge clk);
         check($sformatf("ret_seq_F_stall_%0d", c), 64'(ctl_a[6]), (c < 3) ? 64'd1 : 64'd0);
         check($sformatf("ret_seq_D_bubble_%0d", c), 64'(ctl_a[4]), (c < 3) ? 64'd1 : 64'd0);
         tick();
      end

      // ADR reaches Writeback at RUN cycle 10
      do_reset();
      for (int c = 0; c < 10; c++) tick();
      W_stat = 3'd3;
      @(negedge clk);
      check("adr_mb_ws", 64'(ctl_a[2:1]), 64'd3);
      tick();
      W_stat = 3'd1;
      @(negedge clk);
      check("adr_drain_stat", 64'(stat_a), 64'd3);
      check("adr_drain_halted", 64'(halted_a), 64'd0);
      check("adr_drain_ctrl", 64'(ctl_a), 64'(C_HOLD));
      check("adr_drain_retired", ret_a, 64'd10);
      tick();
      @(negedge clk);
      check("adr_halted", 64'(halted_a), 64'd1);
      check("adr_halted_ctrl", 64'(ctl_a), 64'(C_HOLD));
      tick(); tick();
      check("adr_retired_frozen", ret_a, 64'd10);
      check("adr_cycles_frozen", cyc_a, 64'd11);
      check("adr_stat_held", 64'(stat_a), 64'd3);

      // Watchdog with MAX_CYCLES = 20 on an OPQ loop
      do_reset();
      E_icode = 4'h6;
      for (int c = 0; c < 19; c++) tick();
      @(negedge clk);
      check("wd_pre_halted", 64'(halted_w), 64'd0);
      check("wd_pre_cycles", cyc_w, 64'd19);
      tick();
      check("wd_halted", 64'(halted_w), 64'd1);
      check("wd_stat", 64'(stat_w), 64'd2);
      check("wd_trip", 64'(wd_w), 64'd1);
      check("wd_cycles", cyc_w, 64'd20);
      tick(); tick();
      check("wd_cycles_frozen", cyc_w, 64'd20);
      check("wd_trip_sticky", 64'(wd_w), 64'd1);

      // Exception on the same cycle the watchdog would fire
      do_reset();
      for (int c = 0; c < 19; c++) tick();
      W_stat = 3'd4;
      tick();
      W_stat = 3'd1;
      check("wdx_stat", 64'(stat_w), 64'd4);
      check("wdx_trip", 64'(wd_w), 64'd0);
      check("wdx_drain_halted", 64'(halted_w), 64'd0);
      tick();
      check("wdx_halted", 64'(halted_w), 64'd1);
      check("wdx_trip_after", 64'(wd_w), 64'd0);

      // Saturation with CNT_W = 4, then reset out of HALTED
      do_reset();
      for (int c = 0; c < 20; c++) tick();
      check("sat_cycles", 64'(cyc_s), 64'd15);
      check("sat_retired", 64'(ret_s), 64'd15);
      W_stat = 3'd3;
      tick();
      W_stat = 3'd1;
      tick();
      check("sat_halted", 64'(halted_s), 64'd1);
      check("sat_stat", 64'(stat_s), 64'd3);
      rst = 1'b1;
      @(negedge clk);
      check("sat_rst_ctrl", 64'(ctl_s), 64'(C_RST));
      tick();
      rst = 1'b0;
      check("sat_rst_stat", 64'(stat_s), 64'd1);
      check("sat_rst_halted", 64'(halted_s), 64'd0);
      check("sat_rst_cycles", 64'(cyc_s), 64'd0);
      check("sat_rst_retired", 64'(ret_s), 64'd0);
      @(negedge clk);
      check("sat_run_ctrl", 64'(ctl_s), 64'd0);
      tick();
      check("sat_run_cycles", 64'(cyc_s), 64'd1);

      // Randomized run against the reference model
      do_reset();
      md_mode = 0; md_stat = 3'd1; md_halted = 0; md_wd = 0; md_cyc = 0; md_ret = 0;
      for (int c = 0; c < 400; c++) begin
         int r;
         rst     = ($urandom_range(0, 29) == 0);
         D_icode = 4'($urandom_range(0, 15));
         E_icode = 4'($urandom_range(0, 15));
         M_icode = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 4); d_srcA = (r == 4) ? 4'hF : 4'(r);
         r = $urandom_range(0, 4); d_srcB = (r == 4) ? 4'hF : 4'(r);
         r = $urandom_range(0, 4); E_dstM = (r == 4) ? 4'hF : 4'(r);
         e_Cnd   = 1'($urandom_range(0, 1));
         m_stat  = 3'($urandom_range(0, 4));
         W_stat  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4))
                                                : 3'($urandom_range(0, 1));
         @(negedge clk);
         check("rnd_ctrl", 64'(ctl_a), 64'(model_ctrl()));
         check("rnd_stat", 64'(stat_a), 64'(md_stat));
         check("rnd_halted", 64'(halted_a), 64'(md_halted));
         check("rnd_wdog", 64'(wd_a), 64'(md_wd));
         check("rnd_cycles", cyc_a, md_cyc);
         check("rnd_retired", ret_a, md_ret);
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
